// File: rtl/mvm_pipe.sv
// Matrix-vector multiply y = A*x. A and x are loaded word-serially, P MAC lanes accumulate rows in
// parallel, and the results drain through a ready/valid port. Optional macro MVM_RELU_EN clamps outputs at 0.

module mvm_lane #(
  parameter int B  = 16,
  parameter int OW = 36,
  parameter int G  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vld,
  input  logic                 last,
  input  logic signed [B-1:0]  a,
  input  logic signed [B-1:0]  x,
  output logic                 res_vld,
  output logic signed [OW-1:0] res
);
  logic signed [2*B-1:0] prod, prod_s;
  logic signed [OW-1:0]  prod_e, acc;
  wire  [G:0]            vld_pipe, last_pipe;

  assign prod         = a * x;
  assign vld_pipe[0]  = vld;
  assign last_pipe[0] = last;

  generate
    if (G > 0) begin : g_pipe
      logic                  vld_q, last_q;
      logic signed [2*B-1:0] prod_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          vld_q  <= 1'b0;
          last_q <= 1'b0;
          prod_q <= '0;
        end else begin
          vld_q  <= vld_pipe[0];
          last_q <= last_pipe[0];
          prod_q <= prod;
        end
      end
      assign vld_pipe[G]  = vld_q;
      assign last_pipe[G] = last_q;
      assign prod_s       = prod_q;
    end else begin : g_nopipe
      assign prod_s = prod;
    end
  endgenerate

  assign prod_e = OW'(prod_s);

  // Accumulator restarts on the last column so the next row begins from zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      res     <= '0;
      res_vld <= 1'b0;
    end else begin
      res_vld <= vld_pipe[G] && last_pipe[G];
      if (vld_pipe[G]) begin
        if (last_pipe[G]) begin
          res <= acc + prod_e;
          acc <= '0;
        end else begin
          acc <= acc + prod_e;
        end
      end
    end
  end
endmodule

module mvm_pipe #(
  parameter  int M  = 12,
  parameter  int N  = 12,
  parameter  int P  = 1,
  parameter  int B  = 16,
  parameter  int G  = 1,
  localparam int OW = 2*B + $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 loadMatrix,
  input  logic                 loadVector,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [B-1:0]         data_in,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic signed [OW-1:0] data_out,
  output logic                 busy,
  output logic                 done
);
  localparam int R   = M / P;
  localparam int K   = R * N;
  localparam int AMW = (M*N > 1) ? $clog2(M*N) : 1;
  localparam int RW  = (R > 1) ? $clog2(R) : 1;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;
  localparam int YW  = (M > 1) ? $clog2(M) : 1;
  localparam int TW  = $clog2(K + G + 2);

  generate
    if ((M % P) != 0 || G < 0 || G > 1) begin : g_bad_cfg
      $error("mvm_pipe: M must be a multiple of P and G must be 0 or 1");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_X, CALC, DRAIN} state_t;
  state_t state, state_nx;

  logic [B-1:0]          a_mem [M*N];
  logic [B-1:0]          x_mem [N];
  logic signed [OW-1:0]  y_mem [M];

  logic [AMW-1:0]        ld_cnt;
  logic [TW-1:0]         calc_cnt;
  logic [RW-1:0]         r_idx, wr_row;
  logic [CW-1:0]         c_idx;
  logic [YW-1:0]         rd_idx;
  logic                  a_ok, x_ok, done_q;
  logic                  issue, last_col;

  logic [P-1:0][B-1:0]   a_lane;
  logic [P-1:0]          res_vld;
  logic [P-1:0][OW-1:0]  res;
  logic signed [OW-1:0]  y_rd;

  assign issue    = (state == CALC) && (calc_cnt < TW'(K));
  assign last_col = (c_idx == CW'(N-1));
  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign out_valid = (state == DRAIN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (loadMatrix)                  state_nx = LOAD_A;
        else if (loadVector)             state_nx = LOAD_X;
        else if (start && a_ok && x_ok)  state_nx = CALC;
      end
      LOAD_A: if (in_valid && ld_cnt == AMW'(M*N-1)) state_nx = IDLE;
      LOAD_X: if (in_valid && ld_cnt == AMW'(N-1))   state_nx = IDLE;
      CALC:   if (calc_cnt == TW'(K+G))              state_nx = DRAIN;
      DRAIN:  if (out_ready && rd_idx == YW'(M-1))   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_cnt   <= '0;
      calc_cnt <= '0;
      r_idx    <= '0;
      c_idx    <= '0;
      rd_idx   <= '0;
      a_ok     <= 1'b0;
      x_ok     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          ld_cnt   <= '0;
          calc_cnt <= '0;
          r_idx    <= '0;
          c_idx    <= '0;
          rd_idx   <= '0;
          // A partially loaded operand is never valid.
          if (loadMatrix)      a_ok <= 1'b0;
          else if (loadVector) x_ok <= 1'b0;
        end
        LOAD_A: if (in_valid) begin
          if (ld_cnt == AMW'(M*N-1)) begin
            ld_cnt <= '0;
            a_ok   <= 1'b1;
          end else begin
            ld_cnt <= ld_cnt + 1'b1;
          end
        end
        LOAD_X: if (in_valid) begin
          if (ld_cnt == AMW'(N-1)) begin
            ld_cnt <= '0;
            x_ok   <= 1'b1;
          end else begin
            ld_cnt <= ld_cnt + 1'b1;
          end
        end
        CALC: begin
          calc_cnt <= calc_cnt + 1'b1;
          if (issue) begin
            if (last_col) begin
              c_idx <= '0;
              r_idx <= r_idx + 1'b1;
            end else begin
              c_idx <= c_idx + 1'b1;
            end
          end
        end
        DRAIN: if (out_ready) begin
          rd_idx <= rd_idx + 1'b1;
          if (rd_idx == YW'(M-1)) done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Operand memories are not reset; a_ok/x_ok gate their use.
  always_ff @(posedge clk) begin
    if (state == LOAD_A && in_valid) a_mem[ld_cnt] <= data_in;
    if (state == LOAD_X && in_valid) x_mem[ld_cnt[CW-1:0]] <= data_in;
  end

  always_comb begin
    for (int j = 0; j < P; j++)
      a_lane[j] = a_mem[AMW'((int'(r_idx) * P + j) * N + int'(c_idx))];
  end

  genvar gj;
  generate
    for (gj = 0; gj < P; gj++) begin : g_lane
      mvm_lane #(.B(B), .OW(OW), .G(G)) u_lane (
        .clk     (clk),
        .reset   (reset),
        .vld     (issue),
        .last    (last_col),
        .a       (a_lane[gj]),
        .x       (x_mem[c_idx]),
        .res_vld (res_vld[gj]),
        .res     (res[gj])
      );
    end
  endgenerate

  // Lanes run in lockstep, so one row counter addresses every lane's result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_row <= '0;
      for (int i = 0; i < M; i++) y_mem[i] <= '0;
    end else if (state != CALC) begin
      wr_row <= '0;
    end else begin
      for (int j = 0; j < P; j++)
        if (res_vld[j]) y_mem[YW'(int'(wr_row) * P + j)] <= res[j];
      if (res_vld[0]) wr_row <= wr_row + 1'b1;
    end
  end

  assign y_rd = y_mem[rd_idx];

  always_comb begin
    data_out = '0;
    if (state == DRAIN) begin
`ifdef MVM_RELU_EN
      data_out = y_rd[OW-1] ? '0 : y_rd;
`else
      data_out = y_rd;
`endif
    end
  end
endmodule

// File: tb/tb_mvm_pipe.sv
// Directed bench for mvm_pipe: a default-size instance and an M=8,N=4,P=4 instance.
module tb_mvm_pipe;
  logic clk = 1'b0;
  logic reset, loadMatrix, loadVector, start, in_valid, out_ready;
  logic [15:0] data_in;
  logic [1:0]  en;

  logic ov0, busy0, done0, ov1, busy1, done1;
  logic signed [35:0] dout0;
  logic signed [33:0] dout1;
  logic signed [63:0] dout;
  logic ov, busy, done;

  int errors = 0, checks = 0;
  longint wbuf [144];
  longint ybuf [12];

  always #5 clk = ~clk;

  assign dout = en[1] ? 64'(dout1) : 64'(dout0);
  assign ov   = en[1] ? ov1   : ov0;
  assign busy = en[1] ? busy1 : busy0;
  assign done = en[1] ? done1 : done0;

  mvm_pipe u0 (
    .clk(clk), .reset(reset), .loadMatrix(loadMatrix & en[0]), .loadVector(loadVector & en[0]),
    .start(start & en[0]), .in_valid(in_valid), .data_in(data_in), .out_ready(out_ready),
    .out_valid(ov0), .data_out(dout0), .busy(busy0), .done(done0)
  );

  mvm_pipe #(.M(8), .N(4), .P(4)) u1 (
    .clk(clk), .reset(reset), .loadMatrix(loadMatrix & en[1]), .loadVector(loadVector & en[1]),
    .start(start & en[1]), .in_valid(in_valid), .data_in(data_in), .out_ready(out_ready),
    .out_valid(ov1), .data_out(dout1), .busy(busy1), .done(done1)
  );

  function automatic longint ex(input longint v);
`ifdef MVM_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit is_a, input int cnt, input bit gaps);
    if (is_a) loadMatrix = 1'b1; else loadVector = 1'b1;
    cyc();
    loadMatrix = 1'b0;
    loadVector = 1'b0;
    chk("busy_load", busy, 1);
    for (int i = 0; i < cnt; i++) begin
      if (gaps && (i % 5) == 2) begin
        in_valid = 1'b0;
        data_in  = 16'hDEAD;
        cyc();
        cyc();
      end
      in_valid = 1'b1;
      data_in  = 16'(wbuf[i]);
      cyc();
    end
    in_valid = 1'b0;
    chk("busy_after_load", busy, 0);
  endtask

  task automatic run(input int calc_len, input int nel, input bit toggle);
    int n, idx, k;
    bit held_v, rdy;
    logic signed [63:0] held;
    start = 1'b1;
    cyc();
    start = 1'b0;
    n = 0;
    while (!ov && n < 400) begin
      n++;
      cyc();
    end
    chk("calc_len", n, calc_len);
    idx = 0; k = 0; held_v = 0; held = '0;
    while (idx < nel && k < 200) begin
      if (held_v) chk("stall_hold", dout, held);
      rdy = toggle ? ((k % 2) == 0) : 1'b1;
      out_ready = rdy;
      if (ov) begin
        if (rdy) begin
          chk("y", dout, ybuf[idx]);
          idx++;
          held_v = 0;
        end else begin
          held   = dout;
          held_v = 1;
        end
      end else begin
        chk("ov_drain", ov, 1);
      end
      cyc();
      k++;
    end
    chk("n_out", idx, nel);
    chk("done_pulse", done, 1);
    chk("ov_after", ov, 0);
    chk("busy_after", busy, 0);
    chk("dout_after", dout, 0);
    out_ready = 1'b1;
    cyc();
    chk("done_clear", done, 0);
  endtask

  initial begin
    reset = 1'b0; loadMatrix = 1'b0; loadVector = 1'b0; start = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; data_in = '0; en = 2'b01;
    #1;
    chk("rst_ov", ov0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_dout", dout0, 0);
    cyc(); cyc();
    reset = 1'b1;
    cyc();

    // start without operands is ignored
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_noload_busy", busy, 0);
    cyc();
    chk("start_noload_busy2", busy, 0);

    // identity A (with in_valid gaps), x = 1..12
    for (int i = 0; i < 144; i++) wbuf[i] = ((i / 12) == (i % 12)) ? 1 : 0;
    load(1'b1, 144, 1'b1);
    for (int i = 0; i < 12; i++) wbuf[i] = i + 1;
    load(1'b0, 12, 1'b0);
    for (int i = 0; i < 12; i++) ybuf[i] = i + 1;
    run(146, 12, 1'b0);
    // back-to-back start with stalling consumer
    run(146, 12, 1'b1);

    // reload only x; identity A retained
    for (int i = 0; i < 12; i++) wbuf[i] = -32768;
    load(1'b0, 12, 1'b0);
    for (int i = 0; i < 12; i++) ybuf[i] = ex(-32768);
    run(146, 12, 1'b0);

    // full-scale negative operands
    for (int i = 0; i < 144; i++) wbuf[i] = -32768;
    load(1'b1, 144, 1'b0);
    for (int i = 0; i < 12; i++) ybuf[i] = 64'sd12884901888;
    run(146, 12, 1'b1);

    // reset during CALC
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    chk("calc_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_ov", ov, 0);
    chk("abort_dout", dout, 0);
    chk("abort_done", done, 0);
    cyc();
    reset = 1'b1;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_after_abort", busy, 0);
    cyc();
    chk("ov_after_abort", ov, 0);

    // 8x4 matrix, 4 lanes: A all 2, x all -3
    en = 2'b10;
    for (int i = 0; i < 32; i++) wbuf[i] = 2;
    load(1'b1, 32, 1'b0);
    for (int i = 0; i < 4; i++) wbuf[i] = -3;
    load(1'b0, 4, 1'b0);
    for (int i = 0; i < 8; i++) ybuf[i] = ex(-24);
    run(10, 8, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
